// File: rtl/network_access_port.sv
// Client front end for one cache-mesh access port: a request FIFO that feeds the network one strobe at a time.
// Optional macro NETWORK_ACCESS_PORT_TIMEOUT_EN adds a WAIT_READ timeout that returns an error response.
module network_access_port #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [ADDR_WIDTH-1:0]         net_destAddr,
    output logic                          net_read,
    output logic                          net_write,
    output logic [DATA_WIDTH-1:0]         net_data,
    input  logic                          net_readReady,
    input  logic [DATA_WIDTH-1:0]         net_dataOut
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_READ
    } state_t;

    logic [ADDR_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data  [FIFO_DEPTH];
    logic                  r_fifo_write [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    state_t                r_state;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [ADDR_WIDTH-1:0] r_dest_addr;
    logic [DATA_WIDTH-1:0] r_net_data;
    logic                  r_net_read;
    logic                  r_net_write;
    logic                  w_push;
    logic                  w_pop;

    assign req_ready    = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push       = req_valid && req_ready;
    assign w_pop        = (r_state == IDLE) && (r_count != '0);
    assign fifo_count   = r_count;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign net_destAddr = r_dest_addr;
    assign net_data     = r_net_data;
    assign net_read     = r_net_read;
    assign net_write    = r_net_write;

    // Pointer increments wrap naturally because FIFO_DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr]  <= req_addr;
                r_fifo_data[r_wr_ptr]  <= req_wdata;
                r_fifo_write[r_wr_ptr] <= req_write;
                r_wr_ptr               <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef NETWORK_ACCESS_PORT_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_rsp_error;

    assign rsp_error = r_rsp_error;
`else
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_dest_addr <= '0;
            r_net_data  <= '0;
            r_net_read  <= 1'b0;
            r_net_write <= 1'b0;
`ifdef NETWORK_ACCESS_PORT_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_rsp_error <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_dest_addr <= r_fifo_addr[r_rd_ptr];
                        r_net_data  <= r_fifo_data[r_rd_ptr];
                        r_net_write <= r_fifo_write[r_rd_ptr];
                        r_net_read  <= !r_fifo_write[r_rd_ptr];
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The strobe still shows which kind of request is in flight.
                    r_net_read  <= 1'b0;
                    r_net_write <= 1'b0;
                    r_state     <= r_net_write ? IDLE : WAIT_READ;
`ifdef NETWORK_ACCESS_PORT_TIMEOUT_EN
                    r_tmo_cnt   <= '0;
`endif
                end
                WAIT_READ: begin
                    if (net_readReady) begin
                        r_rsp_data  <= net_dataOut;
                        r_rsp_valid <= 1'b1;
                        r_state     <= IDLE;
`ifdef NETWORK_ACCESS_PORT_TIMEOUT_EN
                        r_rsp_error <= 1'b0;
`endif
                    end
`ifdef NETWORK_ACCESS_PORT_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
